// File: rtl/rr_pkg.sv
// rr_pkg: shared definitions for the register-read / forwarding stage.
//   REG_ADDR_W, OPCODE_W, FUNC7_W, FUNC3_W : instruction field widths
//   XLEN                                   : data width of the payload struct
//   rr_payload_t                           : payload latched toward execute
//   RR_BUBBLE                              : all-zero payload used for bubbles
package rr_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int OPCODE_W   = 7;
   localparam int FUNC7_W    = 7;
   localparam int FUNC3_W    = 3;

   typedef struct packed {
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       rs1_val;
      logic [XLEN-1:0]       rs2_val;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       imm;
      logic [FUNC7_W-1:0]    func7;
      logic [FUNC3_W-1:0]    func3;
      logic [OPCODE_W-1:0]   opcode;
   } rr_payload_t;

   localparam rr_payload_t RR_BUBBLE = '0;

endpackage

// File: rtl/rr_fwd_stage_if.sv
// rr_fwd_stage_if: bundles every non-clock/reset signal of the register-read
// stage: decode-side instruction + handshake, register-file read data, the
// forwarding bus from in-flight producers, and the execute-side payload.
//   master : decode/regfile/forwarding/execute environment
//   slave  : the rr_fwd_stage itself
interface rr_fwd_stage_if #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 3,
   parameter int CNT_W   = 16
);
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [XLEN-1:0]       in_pc;
   logic [4:0]            in_rs1;
   logic [4:0]            in_rs2;
   logic                  in_rs1_used;
   logic                  in_rs2_used;
   logic [4:0]            in_rd;
   logic [XLEN-1:0]       in_imm;
   logic [6:0]            in_func7;
   logic [2:0]            in_func3;
   logic [6:0]            in_opcode;
   logic [XLEN-1:0]       rf_rs1_val;
   logic [XLEN-1:0]       rf_rs2_val;
   logic [NUM_FWD*5-1:0]  fwd_rd;
   logic [NUM_FWD-1:0]    fwd_wen;
   logic [NUM_FWD-1:0]    fwd_data_valid;
   logic [NUM_FWD*XLEN-1:0] fwd_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       out_pc;
   logic [XLEN-1:0]       out_rs1_val;
   logic [XLEN-1:0]       out_rs2_val;
   logic [XLEN-1:0]       out_imm;
   logic [4:0]            out_rd;
   logic [6:0]            out_func7;
   logic [2:0]            out_func3;
   logic [6:0]            out_opcode;
   logic                  hazard;
   logic [CNT_W-1:0]      stall_cnt;

   modport master (
      output flush, in_valid, in_pc, in_rs1, in_rs2, in_rs1_used, in_rs2_used,
             in_rd, in_imm, in_func7, in_func3, in_opcode,
             rf_rs1_val, rf_rs2_val, fwd_rd, fwd_wen, fwd_data_valid, fwd_data,
             out_ready,
      input  in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
             out_rd, out_func7, out_func3, out_opcode, hazard, stall_cnt
   );

   modport slave (
      input  flush, in_valid, in_pc, in_rs1, in_rs2, in_rs1_used, in_rs2_used,
             in_rd, in_imm, in_func7, in_func3, in_opcode,
             rf_rs1_val, rf_rs2_val, fwd_rd, fwd_wen, fwd_data_valid, fwd_data,
             out_ready,
      output in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
             out_rd, out_func7, out_func3, out_opcode, hazard, stall_cnt
   );

endinterface

// File: rtl/rr_operand_sel.sv
// rr_operand_sel: combinational priority forwarding mux for one source operand.
//   used, rs        : whether the instruction reads this source, and its number
//   rf_val          : register-file read data for rs
//   fwd_*           : producer slots, slot 0 youngest, ascending = older
//   val             : selected operand value
//   hazard          : youngest matching producer has not produced its result
module rr_operand_sel #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 3
) (
   input  logic                    used,
   input  logic [4:0]              rs,
   input  logic [XLEN-1:0]         rf_val,
   input  logic [NUM_FWD*5-1:0]    fwd_rd,
   input  logic [NUM_FWD-1:0]      fwd_wen,
   input  logic [NUM_FWD-1:0]      fwd_data_valid,
   input  logic [NUM_FWD*XLEN-1:0] fwd_data,
   output logic [XLEN-1:0]         val,
   output logic                    hazard
);

   logic found;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // a variable unassigned (which would infer a latch); blocking '=' is
      // correct here because later statements must see earlier updates.
      val    = rf_val;
      hazard = 1'b0;
      found  = 1'b0;
      // x0 never has a producer; unused sources never stall.
      if (used && (rs != 5'd0)) begin
         for (int i = 0; i < NUM_FWD; i++) begin
            // Youngest match wins; it also shadows older slots even when its
            // own data is not ready yet.
            if (!found && fwd_wen[i] && (fwd_rd[5*i +: 5] == rs)) begin
               found = 1'b1;
               if (fwd_data_valid[i]) begin
                  val = fwd_data[XLEN*i +: XLEN];
               end else begin
                  hazard = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/rr_fwd_stage.sv
// rr_fwd_stage: register-read stage between decode and execute.
//   clk, reset : clock and synchronous active-high reset
//   bus        : rr_fwd_stage_if.slave carrying the decode handshake, regfile
//                data, forwarding bus, execute handshake/payload, the
//                combinational hazard flag and the saturating stall counter.
// Payload is registered (1-cycle accept-to-valid latency); it holds under
// backpressure, is replaced by a bubble on hazard/idle, and is killed by flush.
module rr_fwd_stage #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 3,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   rr_fwd_stage_if.slave     bus
);
   import rr_pkg::*;

   logic [XLEN-1:0]  rs1_val;
   logic [XLEN-1:0]  rs2_val;
   logic             rs1_hazard;
   logic             rs2_hazard;
   logic             hazard_c;
   logic             load_en;
   logic             out_valid_q;
   logic [CNT_W-1:0] stall_cnt_q;
   rr_payload_t      payload_q;
   rr_payload_t      payload_d;

   rr_operand_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_sel_rs1 (
      .used           (bus.in_rs1_used),
      .rs             (bus.in_rs1),
      .rf_val         (bus.rf_rs1_val),
      .fwd_rd         (bus.fwd_rd),
      .fwd_wen        (bus.fwd_wen),
      .fwd_data_valid (bus.fwd_data_valid),
      .fwd_data       (bus.fwd_data),
      .val            (rs1_val),
      .hazard         (rs1_hazard)
   );

   rr_operand_sel #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_sel_rs2 (
      .used           (bus.in_rs2_used),
      .rs             (bus.in_rs2),
      .rf_val         (bus.rf_rs2_val),
      .fwd_rd         (bus.fwd_rd),
      .fwd_wen        (bus.fwd_wen),
      .fwd_data_valid (bus.fwd_data_valid),
      .fwd_data       (bus.fwd_data),
      .val            (rs2_val),
      .hazard         (rs2_hazard)
   );

   // Hazard only concerns a real instruction; it ignores flush and out_ready.
   assign hazard_c     = bus.in_valid && (rs1_hazard || rs2_hazard);
   // The output register may be overwritten when empty or being drained.
   assign load_en      = !out_valid_q || bus.out_ready;
   assign bus.in_ready = load_en && !hazard_c && !bus.flush;

   always_comb begin
      payload_d         = RR_BUBBLE;
      payload_d.pc      = bus.in_pc;
      payload_d.rs1_val = rs1_val;
      payload_d.rs2_val = rs2_val;
      payload_d.rd      = bus.in_rd;
      payload_d.imm     = bus.in_imm;
      payload_d.func7   = bus.in_func7;
      payload_d.func3   = bus.in_func3;
      payload_d.opcode  = bus.in_opcode;
   end

   // NOTE: state is updated only with non-blocking '<=' so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the payload is reset too, not just out_valid, so execute
         // never observes stale operands after reset.
         out_valid_q <= 1'b0;
         payload_q   <= RR_BUBBLE;
         stall_cnt_q <= '0;
      end else begin
         if (bus.flush) begin
            out_valid_q <= 1'b0;
            payload_q   <= RR_BUBBLE;
         end else if (load_en) begin
            if (bus.in_valid && !hazard_c) begin
               out_valid_q <= 1'b1;
               payload_q   <= payload_d;
            end else begin
               out_valid_q <= 1'b0;
               payload_q   <= RR_BUBBLE;
            end
         end

         // Counts blocked cycles including those also under backpressure;
         // sticks at all-ones.
         if (hazard_c && !bus.flush && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.hazard      = hazard_c;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_pc      = payload_q.pc;
   assign bus.out_rs1_val = payload_q.rs1_val;
   assign bus.out_rs2_val = payload_q.rs2_val;
   assign bus.out_rd      = payload_q.rd;
   assign bus.out_imm     = payload_q.imm;
   assign bus.out_func7   = payload_q.func7;
   assign bus.out_func3   = payload_q.func3;
   assign bus.out_opcode  = payload_q.opcode;
   assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_rr_fwd_stage.sv
// tb_rr_fwd_stage: directed + randomized bench for rr_fwd_stage (CNT_W=4 so
// counter saturation is reachable). A behavioural model predicts hazard,
// in_ready and the registered outputs every cycle.
module tb_rr_fwd_stage;

   localparam int XLEN    = 32;
   localparam int NUM_FWD = 3;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk;
   logic reset;

   rr_fwd_stage_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) bus ();

   rr_fwd_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Forwarding slots as plain arrays; packed onto the bus each cycle.
   logic [4:0]  fr [NUM_FWD];
   logic        fw [NUM_FWD];
   logic        fv [NUM_FWD];
   logic [31:0] fd [NUM_FWD];

   // Model state: what execute should see after the next edge.
   logic        m_valid;
   logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
   logic [4:0]  m_rd;
   logic [6:0]  m_func7, m_opcode;
   logic [2:0]  m_func3;
   int          m_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Operand value: youngest producer writing rs decides; otherwise regfile.
   task automatic operand(input logic used, input logic [4:0] rs, input logic [31:0] rf,
                          output logic [31:0] v, output logic hz);
      v  = rf;
      hz = 1'b0;
      if (!used || rs == 5'd0) return;
      for (int i = 0; i < NUM_FWD; i++) begin
         if (fw[i] && fr[i] == rs) begin
            if (fv[i]) v = fd[i];
            else       hz = 1'b1;
            return;
         end
      end
   endtask

   task automatic apply();
      for (int i = 0; i < NUM_FWD; i++) begin
         bus.fwd_rd[5*i +: 5]       = fr[i];
         bus.fwd_wen[i]             = fw[i];
         bus.fwd_data_valid[i]      = fv[i];
         bus.fwd_data[XLEN*i +: XLEN] = fd[i];
      end
   endtask

   task automatic clear_fwd();
      for (int i = 0; i < NUM_FWD; i++) begin
         fr[i] = 5'd0; fw[i] = 1'b0; fv[i] = 1'b0; fd[i] = 32'd0;
      end
   endtask

   task automatic set_instr(input logic v, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2);
      bus.in_valid    = v;
      bus.in_rs1      = rs1;
      bus.in_rs1_used = u1;
      bus.in_rs2      = rs2;
      bus.in_rs2_used = u2;
      bus.in_pc       = $urandom;
      bus.in_imm      = $urandom;
      bus.in_rd       = 5'($urandom);
      bus.in_func7    = 7'($urandom);
      bus.in_func3    = 3'($urandom);
      bus.in_opcode   = 7'($urandom);
      bus.rf_rs1_val  = $urandom;
      bus.rf_rs2_val  = $urandom;
   endtask

   // One clock: check combinational outputs, advance the model, check regs.
   task automatic tick();
      logic [31:0] v1, v2;
      logic        h1, h2, h, ld;
      apply();
      #1;
      operand(bus.in_rs1_used, bus.in_rs1, bus.rf_rs1_val, v1, h1);
      operand(bus.in_rs2_used, bus.in_rs2, bus.rf_rs2_val, v2, h2);
      h  = bus.in_valid && (h1 || h2);
      ld = !m_valid || bus.out_ready;
      check("hazard", {31'd0, bus.hazard}, {31'd0, h});
      if (!reset) check("in_ready", {31'd0, bus.in_ready}, {31'd0, ld && !h && !bus.flush});

      if (reset) begin
         m_valid = 1'b0; m_cnt = 0;
         {m_pc, m_rs1, m_rs2, m_imm, m_rd, m_func7, m_func3, m_opcode} = '0;
      end else begin
         if (h && !bus.flush && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
         if (bus.flush || (ld && !(bus.in_valid && !h))) begin
            m_valid = 1'b0;
            {m_pc, m_rs1, m_rs2, m_imm, m_rd, m_func7, m_func3, m_opcode} = '0;
         end else if (ld) begin
            m_valid = 1'b1;
            m_pc = bus.in_pc; m_rs1 = v1; m_rs2 = v2; m_imm = bus.in_imm;
            m_rd = bus.in_rd; m_func7 = bus.in_func7; m_func3 = bus.in_func3;
            m_opcode = bus.in_opcode;
         end
      end

      @(posedge clk);
      #1;
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      check("out_pc", bus.out_pc, m_pc);
      check("out_rs1_val", bus.out_rs1_val, m_rs1);
      check("out_rs2_val", bus.out_rs2_val, m_rs2);
      check("out_imm", bus.out_imm, m_imm);
      check("out_rd", {27'd0, bus.out_rd}, {27'd0, m_rd});
      check("out_func7", {25'd0, bus.out_func7}, {25'd0, m_func7});
      check("out_func3", {29'd0, bus.out_func3}, {29'd0, m_func3});
      check("out_opcode", {25'd0, bus.out_opcode}, {25'd0, m_opcode});
      check("stall_cnt", {28'd0, bus.stall_cnt}, 32'(m_cnt));
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      m_valid = 1'b0; m_cnt = 0;
      {m_pc, m_rs1, m_rs2, m_imm, m_rd, m_func7, m_func3, m_opcode} = '0;
      reset = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      clear_fwd();
      set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);

      // Reset state
      tick(); tick();
      check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
      reset = 1'b0;

      // Youngest producer wins
      set_instr(1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
      fr[0] = 5'd5; fw[0] = 1'b1; fv[0] = 1'b1; fd[0] = 32'hAAAA;
      fr[1] = 5'd5; fw[1] = 1'b1; fv[1] = 1'b1; fd[1] = 32'hBBBB;
      tick();
      check("youngest_valid", {31'd0, bus.out_valid}, 32'd1);
      check("youngest_rs1", bus.out_rs1_val, 32'hAAAA);

      // Load-use: two stall cycles then forwarded value
      reset = 1'b1; clear_fwd(); set_instr(1'b0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
      reset = 1'b0;
      set_instr(1'b1, 5'd3, 1'b0, 5'd7, 1'b1);
      fr[0] = 5'd7; fw[0] = 1'b1; fv[0] = 1'b0; fd[0] = 32'hDEAD;
      fr[1] = 5'd7; fw[1] = 1'b1; fv[1] = 1'b1; fd[1] = 32'h5555;
      tick(); tick();
      check("loaduse_cnt", {28'd0, bus.stall_cnt}, 32'd2);
      check("loaduse_bubble", {31'd0, bus.out_valid}, 32'd0);
      fv[0] = 1'b1; fd[0] = 32'h1234;
      tick();
      check("loaduse_rs2", bus.out_rs2_val, 32'h1234);

      // x0 and unused source never stall
      clear_fwd();
      set_instr(1'b1, 5'd0, 1'b1, 5'd9, 1'b0);
      fr[0] = 5'd0; fw[0] = 1'b1; fv[0] = 1'b0;
      fr[1] = 5'd9; fw[1] = 1'b1; fv[1] = 1'b0;
      tick();
      check("x0_rs1", bus.out_rs1_val, bus.rf_rs1_val);

      // Backpressure: accept, then hold 3 cycles while forwarding changes
      clear_fwd();
      set_instr(1'b1, 5'd4, 1'b1, 5'd6, 1'b1);
      fr[0] = 5'd4; fw[0] = 1'b1; fv[0] = 1'b1; fd[0] = 32'hC0FFEE;
      tick();
      check("bp_rs1", bus.out_rs1_val, 32'hC0FFEE);
      bus.out_ready = 1'b0;
      set_instr(1'b1, 5'd4, 1'b1, 5'd6, 1'b1);
      for (int k = 0; k < 3; k++) begin
         fd[0] = $urandom;
         tick();
      end
      check("bp_held_rs1", bus.out_rs1_val, 32'hC0FFEE);
      bus.out_ready = 1'b1;
      tick();

      // Flush with acceptable instruction, then flush during hazard
      clear_fwd();
      set_instr(1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
      bus.flush = 1'b1;
      tick();
      check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
      check("flush_pc", bus.out_pc, 32'd0);
      fr[2] = 5'd2; fw[2] = 1'b1; fv[2] = 1'b0;
      tick();
      bus.flush = 1'b0;

      // Saturation of the stall counter
      reset = 1'b1; clear_fwd(); tick(); reset = 1'b0;
      set_instr(1'b1, 5'd8, 1'b1, 5'd0, 1'b0);
      fr[0] = 5'd8; fw[0] = 1'b1; fv[0] = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      check("sat_cnt", {28'd0, bus.stall_cnt}, CNT_MAX);

      // Reset while holding a payload
      fv[0] = 1'b1; fd[0] = 32'h77;
      bus.out_ready = 1'b0;
      tick(); tick();
      check("hold_before_reset", {31'd0, bus.out_valid}, 32'd1);
      reset = 1'b1;
      tick();
      check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_cnt", {28'd0, bus.stall_cnt}, 32'd0);
      check("rst_rs1", bus.out_rs1_val, 32'd0);
      reset = 1'b0;

      // Randomized traffic with a small register space to provoke matches
      for (int n = 0; n < 300; n++) begin
         reset         = ($urandom_range(0, 49) == 0);
         bus.flush     = ($urandom_range(0, 9) == 0);
         bus.out_ready = ($urandom_range(0, 9) < 7);
         set_instr($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom));
         for (int i = 0; i < NUM_FWD; i++) begin
            fr[i] = 5'($urandom_range(0, 3));
            fw[i] = 1'($urandom);
            fv[i] = 1'($urandom);
            fd[i] = $urandom;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_fwd_stage.md
Name: rr_fwd_stage

Overview:
Parametrised register-read stage between decode and execute. Reads operands from the register file and forwards them from NUM_FWD in-flight producers, with priority given to the youngest producer. Detects read-after-write hazards where a producer's result is not yet available. Drives a valid/ready pipeline register to execute, with bubble insertion, flush, and a saturating hazard-stall counter.

Parameters:
XLEN, 32, operand/data width
NUM_FWD, 3, number of forwarding sources; index 0 = youngest (EX), ascending = older
CNT_W, 16, width of hazard-stall counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  redirect/branch taken; kill stage contents
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts instruction this cycle
in_pc  in  XLEN  instruction PC
in_rs1, in_rs2  in  5 each  source register numbers
in_rs1_used, in_rs2_used  in  1 each  instruction actually reads rs1/rs2
in_rd  in  5  destination register
in_imm  in  XLEN  immediate
in_func7  in  7  funct7
in_func3  in  3  funct3
in_opcode  in  7  opcode
rf_rs1_val, rf_rs2_val  in  XLEN each  register-file read data
fwd_rd  in  NUM_FWD*5  producer rd, slot i at [5i+4:5i]
fwd_wen  in  NUM_FWD  producer will write its rd
fwd_data_valid  in  NUM_FWD  producer result available this cycle
fwd_data  in  NUM_FWD*XLEN  producer result, slot i at [XLEN*i+XLEN-1:XLEN*i]
out_valid  out  1  execute-side payload valid
out_ready  in  1  execute accepts payload
out_pc, out_rs1_val, out_rs2_val, out_imm  out  XLEN each  registered payload
out_rd  out  5  registered payload
out_func7  out  7  registered payload
out_func3  out  3  registered payload
out_opcode  out  7  registered payload
hazard  out  1  combinational: current instruction blocked by RAW hazard
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Operand select, per source s in {rs1, rs2}, combinational:
  - If !used or rs==0: value = rf value; no hazard.
  - Otherwise scan slots 0..NUM_FWD-1. The first slot with fwd_wen && fwd_rd==rs wins.
    - If that slot has fwd_data_valid: value = fwd_data.
    - Else: hazard for that source.
  - No winning slot: value = rf value.
  - Older matching slots are ignored once a younger slot matches, even if the younger slot's data is invalid.
- hazard = in_valid && (rs1 hazard || rs2 hazard). It is independent of out_ready and flush.
- load_en = !out_valid || out_ready.
- in_ready = load_en && !hazard && !flush.
- Register update, priority order:
  1. reset: all payload outputs 0, out_valid 0, stall_cnt 0.
  2. flush: out_valid 0, payload zeroed. A handshake on the same cycle is discarded.
  3. load_en && in_valid && !hazard: capture payload with selected operands; out_valid 1. Latency is 1 cycle from accept to out_valid.
  4. load_en otherwise (bubble, i.e. hazard or !in_valid): out_valid 0, payload zeroed.
  5. !load_en: hold all outputs unchanged. This is backpressure; a payload is never lost or duplicated.
- stall_cnt: increments on every cycle with hazard && !flush && !reset. It saturates at all-ones and never wraps.
- Forward data is sampled in the accepting cycle only. Operands are not re-evaluated while held under backpressure.
- Reset mid-operation discards any held payload. in_ready during reset is not specified; decode must ignore it.

Decomposition:
- Package rr_pkg:
  - REG_ADDR_W=5, OPCODE_W=7, FUNC7_W=7, FUNC3_W=3.
  - Typedef rr_payload_t (pc, rs1_val, rs2_val, rd, imm, func7, func3, opcode), parametrised via XLEN localparam.
  - Constant RR_BUBBLE (all-zero payload).
- Sub-module rr_operand_sel: combinational priority forward mux for one source. It is instantiated twice (rs1, rs2) and outputs value and hazard.

Test Plan:
- Forward youngest wins: rs1=5; slot0 rd=5 valid data 0xAAAA; slot1 rd=5 valid data 0xBBBB; out_ready=1 -> next cycle out_valid=1, out_rs1_val=0xAAAA.
- Load-use hazard: rs2=7 used; slot0 rd=7 wen=1 data_valid=0 for 2 cycles, then data_valid=1 data=0x1234 -> in_ready=0 for 2 cycles, bubbles emitted (out_valid=0), stall_cnt=2, then out_rs2_val=0x1234.
- x0 and unused operand: rs1=0 with slot0 rd=0 wen=1 data_valid=0 -> no hazard, out_rs1_val=rf value. Also in_rs2_used=0 with a matching pending slot -> no hazard.
- Backpressure: payload accepted, out_ready=0 for 3 cycles while forward data changes -> outputs held bit-exact, in_ready=0, then released intact.
- Flush with hazard and with accept: flush=1 while in_valid=1, no hazard -> in_ready=0, out_valid=0 next cycle, payload 0. Flush during hazard -> stall_cnt does not increment.
- Saturation/reset: CNT_W=4, 20 hazard cycles -> stall_cnt=15. Assert reset mid-hold -> out_valid=0, stall_cnt=0, all payload 0 next cycle.
